axis_classifier_framer: RTL and testbench
=========================================

Name: axis_classifier_framer

Overview:
- Parametrised successor to the team's pass-through AXI-Stream classifier wrapper.
- Buffers the stream in a synchronous FIFO and forwards it with full backpressure.
- Tracks per-frame word and byte counts; optionally appends a trailer word carrying those counts.
- Truncates oversize frames. Sits between the DMA MM2S stream and the classifier core.

Parameters:
- DATA_WIDTH, 32, stream data width in bits; must be ≥32 and a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- FIFO_DEPTH, 16, input FIFO entries; power of 2, ≥2.
- MAX_WORDS, 1024, maximum words per output frame; range 1..65535.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of frame.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- cfg_trailer_en  in  1  append trailer word to each frame.
- stat_frame_count  out  32  frames emitted; wraps modulo 2^32.
- stat_trunc  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; state PASS; counters cleared.
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, stat_frame_count=0, stat_trunc=0.
  - s_axis_tready is held 0 while rst=1.
  - Reset mid-frame discards all buffered data; no partial trailer is emitted.
- Input side:
  - s_axis_tready = !fifo_full.
  - Each transfer (tvalid&tready) writes {tdata,tkeep,tlast}.
  - A write and a read in the same cycle are both allowed and leave the occupancy unchanged.
- Output register:
  - Loaded from the FIFO head when empty, or when the current word is transferred.
  - A word accepted at edge N, with the FIFO and output register empty, shows m_axis_tvalid=1 after edge N+1.
  - Sustained throughput is 1 word/cycle with tready held high.
  - Once tvalid=1, tdata/tkeep/tlast are held stable until tready=1.
- Per-frame counters, updated on output transfers of data words:
  - wcnt (16 bit): +1 per word.
  - bcnt (16 bit): +popcount(tkeep) per word, saturating at 0xFFFF.
  - A tkeep=0 word counts as 1 word and 0 bytes.
- cfg_trailer_en is latched as trl_en when the first word of a frame is loaded. Changes mid-frame have no effect until the next frame.
- FSM states PASS, TRAILER, DISCARD:
  - PASS, last data word (input tlast, or wcnt reaches MAX_WORDS), trl_en=0:
    - Word emitted with tlast=1.
    - stat_frame_count +1 on its transfer; counters cleared.
  - PASS, last data word, trl_en=1:
    - Word emitted with tlast=0; go to TRAILER.
  - TRAILER:
    - Emit tdata = zero-extended {bcnt,wcnt} (wcnt in [15:0], bcnt in [31:16]), tkeep all ones, tlast=1.
    - Counts include the final data word.
    - On transfer: stat_frame_count +1, counters cleared.
    - Next state is PASS, or DISCARD if the frame was truncated.
  - Truncation: the MAX_WORDS-th word without input tlast is forced to tlast (or triggers the trailer).
    - stat_trunc pulses on that word's transfer.
    - Then go to DISCARD (after the trailer, if enabled).
  - DISCARD:
    - Pop FIFO words at 1/cycle with m_axis_tvalid=0, up to and including the word with input tlast.
    - Then return to PASS.
    - Input backpressure continues normally.
  - A frame whose input tlast falls exactly on word MAX_WORDS is not truncated: no stat_trunc pulse, no DISCARD.
- FIFO full:
  - s_axis_tready=0; no data is lost.
  - With m_axis_tready low indefinitely, exactly FIFO_DEPTH+1 words are accepted.

Decomposition:
- Package classifier_pkg:
  - state enum {PASS, TRAILER, DISCARD}.
  - Trailer field widths and offsets (WCNT_LSB=0, BCNT_LSB=16, CNT_W=16).
  - popcount function over KEEP_WIDTH.
- Sub-module axis_sync_fifo (width DATA_WIDTH+KEEP_WIDTH+1, depth FIFO_DEPTH):
  - Synchronous reset.
  - full/empty flags; pointers one bit wider than the address for the wrap distinction.

Test Plan:
- Pass-through, cfg_trailer_en=0, 4-word frame tkeep=F, tready=1 -> same 4 words out, tlast on word 4, stat_frame_count=1, first output 1 cycle after first accept.
- Trailer, cfg_trailer_en=1, 3 words with tkeep F,F,3 -> words 1–3 with tlast=0, then trailer 0x000A_0003 with tlast=1.
- Backpressure, m_axis_tready=0 while 20 words offered, FIFO_DEPTH=16 -> exactly 17 accepted, s_axis_tready=0; releasing tready delivers all 20 in order with stable data during stalls.
- Truncation, MAX_WORDS=4, 7-word input frame followed by a 2-word frame, trailer off:
  - 4 words out with tlast on word 4; stat_trunc pulses once; words 5–7 dropped.
  - Next frame intact; stat_frame_count=2.
- Reset mid-frame after 2 of 5 words -> outputs zero; a following 2-word frame emits cleanly with stat_frame_count=1.
- cfg_trailer_en toggled mid-frame -> no effect on the current frame; applies from the next frame.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared types, trailer layout and byte-count helper for the classifier framer.
package classifier_pkg;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        TRAILER = 2'd1,
        DISCARD = 2'd2
    } state_e;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned WCNT_LSB = 0;
    localparam int unsigned BCNT_LSB = 16;
    localparam int unsigned KEEP_MAX = 128;

    // Callers zero-extend their tkeep to KEEP_MAX bits.
    function automatic logic [CNT_W:0] popcount(input logic [KEEP_MAX-1:0] keep);
        logic [CNT_W:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            cnt = cnt + (CNT_W+1)'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a combinational head; pointers carry an extra wrap bit.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/axis_classifier_framer.sv
// AXI-Stream framer: FIFO-buffered pass-through with per-frame counts,
// optional count trailer and truncation of frames longer than MAX_WORDS.
module axis_classifier_framer
    import classifier_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH/8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic                  cfg_trailer_en,
    output logic [31:0]           stat_frame_count,
    output logic                  stat_trunc
);

    localparam int unsigned    FW    = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_WORDS);

    logic [FW-1:0]         fifo_wdata, fifo_rdata;
    logic                  fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic [KEEP_WIDTH-1:0] head_keep;
    logic                  head_last;

    state_e                state_q, state_d;
    logic                  trl_en_q, trl_en_d;
    logic                  trunc_pend_q, trunc_pend_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic [CNT_W-1:0]      bcnt_q, bcnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;
    logic                  out_fend_q, out_fend_d;
    logic                  out_trunc_q, out_trunc_d;
    logic [31:0]           frame_cnt_q, frame_cnt_d;
    logic                  trunc_pulse_q, trunc_pulse_d;

    logic                  out_xfer, load_ok;
    logic                  trl, is_max, end_frame, trunc;
    logic [CNT_W:0]        wcnt_inc, bsum;
    logic [CNT_W-1:0]      bcnt_new;
    logic [DATA_WIDTH-1:0] trailer_word;

    assign s_axis_tready = !fifo_full && !rst;
    assign fifo_wr       = s_axis_tvalid && s_axis_tready;
    assign fifo_wdata    = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign head_data     = fifo_rdata[FW-1 -: DATA_WIDTH];
    assign head_keep     = fifo_rdata[KEEP_WIDTH:1];
    assign head_last     = fifo_rdata[0];

    axis_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .full_o    (fifo_full),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty)
    );

    assign out_xfer  = out_valid_q && m_axis_tready;
    assign load_ok   = !out_valid_q || m_axis_tready;

    // Frame-end and truncation are decided when a word enters the output
    // register, so counts here track words loaded rather than words sent.
    assign wcnt_inc  = {1'b0, wcnt_q} + (CNT_W+1)'(1);
    assign bsum      = {1'b0, bcnt_q} + popcount(KEEP_MAX'(head_keep));
    assign bcnt_new  = bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
    assign trl       = (wcnt_q == '0) ? cfg_trailer_en : trl_en_q;
    assign is_max    = (wcnt_inc == MAX_W);
    assign end_frame = head_last || is_max;
    assign trunc     = is_max && !head_last;

    always_comb begin
        trailer_word = '0;
        trailer_word[WCNT_LSB +: CNT_W] = wcnt_q;
        trailer_word[BCNT_LSB +: CNT_W] = bcnt_q;
    end

    always_comb begin
        state_d       = state_q;
        trl_en_d      = trl_en_q;
        trunc_pend_d  = trunc_pend_q;
        wcnt_d        = wcnt_q;
        bcnt_d        = bcnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_keep_d    = out_keep_q;
        out_last_d    = out_last_q;
        out_fend_d    = out_fend_q;
        out_trunc_d   = out_trunc_q;
        frame_cnt_d   = frame_cnt_q;
        trunc_pulse_d = 1'b0;
        fifo_rd       = 1'b0;

        if (out_xfer) begin
            out_valid_d   = 1'b0;
            trunc_pulse_d = out_trunc_q;
            if (out_fend_q) frame_cnt_d = frame_cnt_q + 32'd1;
        end

        case (state_q)
            PASS: begin
                if (load_ok && !fifo_empty) begin
                    fifo_rd     = 1'b1;
                    trl_en_d    = trl;
                    out_valid_d = 1'b1;
                    out_data_d  = head_data;
                    out_keep_d  = head_keep;
                    out_trunc_d = trunc;
                    if (end_frame && !trl) begin
                        out_last_d = 1'b1;
                        out_fend_d = 1'b1;
                        wcnt_d     = '0;
                        bcnt_d     = '0;
                        state_d    = trunc ? DISCARD : PASS;
                    end else begin
                        out_last_d = 1'b0;
                        out_fend_d = 1'b0;
                        wcnt_d     = wcnt_inc[CNT_W-1:0];
                        bcnt_d     = bcnt_new;
                        if (end_frame) begin
                            trunc_pend_d = trunc;
                            state_d      = TRAILER;
                        end
                    end
                end
            end
            TRAILER: begin
                if (load_ok) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = trailer_word;
                    out_keep_d   = '1;
                    out_last_d   = 1'b1;
                    out_fend_d   = 1'b1;
                    out_trunc_d  = 1'b0;
                    wcnt_d       = '0;
                    bcnt_d       = '0;
                    trunc_pend_d = 1'b0;
                    state_d      = trunc_pend_q ? DISCARD : PASS;
                end
            end
            DISCARD: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    if (head_last) state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PASS;
            trl_en_q      <= 1'b0;
            trunc_pend_q  <= 1'b0;
            wcnt_q        <= '0;
            bcnt_q        <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_keep_q    <= '0;
            out_last_q    <= 1'b0;
            out_fend_q    <= 1'b0;
            out_trunc_q   <= 1'b0;
            frame_cnt_q   <= '0;
            trunc_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            trl_en_q      <= trl_en_d;
            trunc_pend_q  <= trunc_pend_d;
            wcnt_q        <= wcnt_d;
            bcnt_q        <= bcnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_keep_q    <= out_keep_d;
            out_last_q    <= out_last_d;
            out_fend_q    <= out_fend_d;
            out_trunc_q   <= out_trunc_d;
            frame_cnt_q   <= frame_cnt_d;
            trunc_pulse_q <= trunc_pulse_d;
        end
    end

    assign m_axis_tdata     = out_data_q;
    assign m_axis_tkeep     = out_keep_q;
    assign m_axis_tvalid    = out_valid_q;
    assign m_axis_tlast     = out_last_q;
    assign stat_frame_count = frame_cnt_q;
    assign stat_trunc       = trunc_pulse_q;

endmodule

// File: tb/tb_axis_classifier_framer.sv
// Randomized bench for axis_classifier_framer against a frame-level reference model.
module tb_axis_classifier_framer;

    localparam int unsigned DW    = 32;
    localparam int unsigned KW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXW  = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          cfg_trl = 1'b0;
    logic [31:0]   frame_count;
    logic          trunc_o;

    axis_classifier_framer #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .FIFO_DEPTH (DEPTH),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tlast     (m_tlast),
        .cfg_trailer_en   (cfg_trl),
        .stat_frame_count (frame_count),
        .stat_trunc       (trunc_o)
    );

    always #5 clk = ~clk;

    beat_t       tx_q[$];
    beat_t       exp_q[$];
    int unsigned n_chk = 0, n_err = 0;
    int unsigned acc_cnt = 0, trunc_seen = 0, exp_frames = 0, exp_trunc = 0;
    bit          rand_gaps = 0, ready_mode = 0;
    bit          m_disc = 0, m_trl = 0;
    int unsigned m_k = 0, m_wc = 0, m_bc = 0;
    logic [DW-1:0] last_out_data = '0;
    bit          prev_stall = 0;
    beat_t       prev_beat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: each frame yields min(len, MAXW) words, the last one marked
    // end (or followed by a {bytes,words} trailer); the remainder is dropped.
    function automatic void model_accept(input beat_t b, input bit cfg);
        bit    end_f;
        beat_t nb;
        if (m_disc) begin
            if (b.l) m_disc = 0;
            return;
        end
        m_k++;
        if (m_k == 1) m_trl = cfg;
        m_wc++;
        m_bc = m_bc + $countones(b.k);
        if (m_bc > 65535) m_bc = 65535;
        end_f = b.l || (m_k == MAXW);
        nb = '{d: b.d, k: b.k, l: end_f && !m_trl};
        exp_q.push_back(nb);
        if (end_f) begin
            if (m_trl) begin
                nb.d = {m_bc[15:0], m_wc[15:0]};
                nb.k = '1;
                nb.l = 1'b1;
                exp_q.push_back(nb);
            end
            exp_frames++;
            if (!b.l) begin
                exp_trunc++;
                m_disc = 1;
            end
            m_k  = 0;
            m_wc = 0;
            m_bc = 0;
        end
    endfunction

    function automatic void model_reset();
        tx_q.delete();
        exp_q.delete();
        m_disc = 0; m_trl = 0; m_k = 0; m_wc = 0; m_bc = 0;
        exp_frames = 0; exp_trunc = 0; trunc_seen = 0;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst && tx_q.size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
            s_tvalid = 1'b1;
            s_tdata  = tx_q[0].d;
            s_tkeep  = tx_q[0].k;
            s_tlast  = tx_q[0].l;
        end else begin
            s_tvalid = 1'b0;
        end
        if (ready_mode) m_tready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (m_tvalid && prev_stall)
                chk("hold_stable", {m_tdata, m_tkeep, m_tlast}, prev_beat);
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = '{d: m_tdata, k: m_tkeep, l: m_tlast};
            if (m_tvalid && m_tready) begin
                chk("out_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_tdata", m_tdata, e.d);
                    chk("out_tkeep", m_tkeep, e.k);
                    chk("out_tlast", m_tlast, e.l);
                end
                last_out_data = m_tdata;
            end
            if (trunc_o) trunc_seen++;
            if (s_tvalid && s_tready && tx_q.size() > 0) begin
                model_accept(tx_q.pop_front(), cfg_trl);
                acc_cnt++;
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        beat_t b;
        b = '{d: d, k: k, l: l};
        tx_q.push_back(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0 && exp_q.size() == 0 && !m_tvalid) break;
        end
        repeat (DEPTH + 4) @(negedge clk);
        chk("drain_pending", exp_q.size() + tx_q.size(), 0);
    endtask

    initial begin
        int unsigned base_f, base_t, base_a;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_frames", frame_count, 0);
        chk("rst_trunc", trunc_o, 0);
        rst = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);

        // Pass-through, 4 words, latency from accept to valid
        base_f = frame_count;
        for (int i = 0; i < 4; i++) push_word(32'h1000_0000 + i, 4'hF, i == 3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_tvalid && s_tready) break;
        end
        @(posedge clk); #2;
        chk("lat_edge_n", m_tvalid, 0);
        @(posedge clk); #2;
        chk("lat_edge_n1", m_tvalid, 1);
        chk("lat_first_data", m_tdata, 32'h1000_0000);
        drain();
        chk("pt_frames", frame_count - base_f, 1);

        // Trailer
        cfg_trl = 1'b1;
        base_f = frame_count;
        push_word(32'hA1, 4'hF, 0);
        push_word(32'hA2, 4'hF, 0);
        push_word(32'hA3, 4'h3, 1);
        drain();
        chk("trl_word", last_out_data, 32'h000A_0003);
        chk("trl_frames", frame_count - base_f, 1);
        cfg_trl = 1'b0;

        // Backpressure
        m_tready = 1'b0;
        base_a = acc_cnt;
        base_f = frame_count;
        for (int i = 0; i < 20; i++) push_word(32'hB000 + i, 4'hF, (i % 4) == 3);
        repeat (60) @(negedge clk);
        chk("bp_accepted", acc_cnt - base_a, 17);
        chk("bp_s_tready", s_tready, 0);
        m_tready = 1'b1;
        drain();
        chk("bp_frames", frame_count - base_f, 5);

        // Truncation: 7-word frame then 2-word frame
        base_f = frame_count;
        base_t = trunc_seen;
        for (int i = 0; i < 7; i++) push_word(32'hC000 + i, 4'hF, i == 6);
        push_word(32'hC100, 4'hF, 0);
        push_word(32'hC101, 4'hF, 1);
        drain();
        chk("trunc_frames", frame_count - base_f, 2);
        chk("trunc_pulses", trunc_seen - base_t, 1);

        // Trailer enable changed mid-frame
        base_f = frame_count;
        push_word(32'hD0, 4'hF, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_tvalid) break;
        end
        cfg_trl = 1'b1;
        push_word(32'hD1, 4'hF, 0);
        push_word(32'hD2, 4'hF, 1);
        push_word(32'hE0, 4'hF, 0);
        push_word(32'hE1, 4'hF, 1);
        drain();
        chk("toggle_trl_word", last_out_data, 32'h0008_0002);
        chk("toggle_frames", frame_count - base_f, 2);
        cfg_trl = 1'b0;

        // Reset mid-frame after 2 of 5 words
        m_tready = 1'b0;
        push_word(32'hF0, 4'hF, 0);
        push_word(32'hF1, 4'hF, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0) break;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("mrst_tvalid", m_tvalid, 0);
        chk("mrst_tdata", m_tdata, 0);
        chk("mrst_tlast", m_tlast, 0);
        chk("mrst_s_tready", s_tready, 0);
        chk("mrst_frames", frame_count, 0);
        rst = 1'b0;
        m_tready = 1'b1;
        push_word(32'h5A0, 4'hF, 0);
        push_word(32'h5A1, 4'hF, 1);
        drain();
        chk("mrst_after_frames", frame_count, 1);

        // Randomized traffic
        ready_mode = 1;
        rand_gaps  = 1;
        for (int b = 0; b < 4; b++) begin
            cfg_trl = b[0];
            for (int f = 0; f < 12; f++) begin
                int unsigned len;
                len = $urandom_range(1, 7);
                for (int unsigned w = 0; w < len; w++)
                    push_word($urandom, 4'($urandom_range(0, 15)), w == len - 1);
            end
            drain();
            chk("rand_frames", frame_count, exp_frames);
            chk("rand_trunc", trunc_seen, exp_trunc);
        end
        ready_mode = 0;
        rand_gaps  = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
